// File: rtl/cube_accum.sv
// cube_accum -- accumulates a fixed number of cube terms from an upstream
// cube pipeline into a 40-bit unsigned sum. The result is held until the
// consumer accepts it.
//
// Ports
//   clock        sole clock, all state on the rising edge
//   reset        asynchronous, active-high; returns the block to IDLE
//   start        single-cycle request to begin an accumulation (IDLE only)
//   count        number of cube terms to sum, sampled with start
//   in_valid     high in the cycle the cube block samples a valid operand
//   cube_result  32-bit unsigned output of the cube block
//   sum          accumulated sum of cubes, held in DONE and in IDLE afterwards
//   sum_valid    sum is final and held (high in DONE)
//   sum_ready    consumer accepts sum when high together with sum_valid
//   busy         high in ACCUM and DONE
module cube_accum #(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [31:0]      cube_result,
  output logic [39:0]      sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [LATENCY-1:0] valid_sr;
  logic               dv;
  logic [CNT_W-1:0]   remaining;
  logic [39:0]        acc;

  // Delay line matching the upstream cube pipeline depth. It runs in every
  // state so terms already in flight when start arrives still line up.
  generate
    if (LATENCY == 1) begin : g_sr_single
      always_ff @(posedge clock or posedge reset) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update together from values sampled before the edge.
        if (reset) valid_sr <= '0;
        else       valid_sr <= in_valid;
      end
    end else begin : g_sr_multi
      always_ff @(posedge clock or posedge reset) begin
        if (reset) valid_sr <= '0;
        else       valid_sr <= {valid_sr[LATENCY-2:0], in_valid};
      end
    end
  endgenerate

  // High at the edge where the matching cube_result is stable.
  assign dv = valid_sr[LATENCY-1];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned,
    // which would otherwise infer a latch.
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (count == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        // remaining is at least 1 here; the last term moves us to DONE on
        // the same edge it is added, so sum_valid rises with the final total.
        if (dv && (remaining == CNT_W'(1))) state_nx = DONE;
      end
      DONE: begin
        // Only honoured while sum_valid is already high, so sum_ready on
        // the DONE entry edge itself has no effect.
        if (sum_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy      = (state != IDLE);
    sum_valid = (state == DONE);
  end

  // Accumulator and term counter. start outside IDLE and dv outside ACCUM
  // fall through untouched, leaving the held sum stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            remaining <= count;
          end
        end
        ACCUM: begin
          if (dv) begin
            // Zero-extended add; wraps modulo 2^40 only for CNT_W > 8.
            acc       <= acc + {8'd0, cube_result};
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum = acc;

endmodule

// File: tb/tb_cube_accum.sv
module tb_cube_accum;

  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] num = '0;
  logic [31:0] cube_result;
  logic [39:0] sum;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cube_accum #(.LATENCY(LAT), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .count       (count),
    .in_valid    (in_valid),
    .cube_result (cube_result),
    .sum         (sum),
    .sum_valid   (sum_valid),
    .sum_ready   (sum_ready),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Upstream cube block model: operand sampled with in_valid at edge E,
  // its 32-bit truncated cube is stable at edge E+LAT. Cycles without a
  // valid operand carry random junk so misaligned accumulation shows up.
  logic [31:0] cp [LAT];
  always @(posedge clock) begin
    cp[0] <= in_valid ? num * num * num : $urandom;
    for (int i = 1; i < LAT; i++) cp[i] <= cp[i-1];
  end
  assign cube_result = cp[LAT-1];

  // Reference: sum of truncated 32-bit cubes, modulo 2^40.
  function automatic logic [39:0] model_sum(input logic [31:0] nums[$]);
    logic [39:0] s;
    logic [31:0] c;
    s = '0;
    foreach (nums[i]) begin
      c = nums[i] * nums[i] * nums[i];
      s = s + {8'd0, c};
    end
    return s;
  endfunction

  // Issues start, then the terms (with up to max_gap idle cycles before each),
  // then waits a bounded time for sum_valid. Reports what it observed.
  task automatic run_txn(input int n, input logic [31:0] nums[$], input int max_gap,
                         output logic [39:0] o_sum, output int o_lat,
                         output bit o_early, output bit o_busy_drop);
    int gap;
    o_early = 0;
    o_busy_drop = 0;
    o_lat = -1;
    start = 1'b1;
    count = 8'(n);
    @(posedge clock); #1;
    start = 1'b0;
    foreach (nums[i]) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        @(posedge clock); #1;
        if (sum_valid) o_early = 1;
        if (!busy) o_busy_drop = 1;
      end
      in_valid = 1'b1;
      num = nums[i];
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (sum_valid) o_early = 1;
      if (!busy) o_busy_drop = 1;
    end
    for (int k = 1; k <= 64; k++) begin
      @(posedge clock); #1;
      if (sum_valid) begin
        o_lat = k;
        break;
      end
      if (!busy) o_busy_drop = 1;
    end
    o_sum = sum;
  endtask

  task automatic accept();
    sum_ready = 1'b1;
    @(posedge clock); #1;
    sum_ready = 1'b0;
  endtask

  task automatic settle();
    start = 1'b0;
    in_valid = 1'b0;
    sum_ready = 1'b0;
    repeat (LAT + 2) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({sum, sum_valid, busy} !== {40'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: sum=%0h sv=%0b busy=%0b expected 0/0/0", sum, sum_valid, busy);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({sum, sum_valid, busy} !== {40'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: sum=%0h sv=%0b busy=%0b expected 0/0/0", sum, sum_valid, busy);
    end
  endtask

  // Three terms 1,2,3; then start/in_valid in DONE are ignored; then
  // in_valid in IDLE is discarded and sum is retained.
  task automatic test_basic();
    logic [31:0] q[$];
    logic [39:0] s;
    int lat;
    bit early, bdrop;
    q = '{32'd1, 32'd2, 32'd3};
    run_txn(3, q, 0, s, lat, early, bdrop);
    checks++;
    if (s !== model_sum(q)) begin
      errors++;
      $display("FAIL basic_sum: got %0d expected %0d", s, model_sum(q));
    end
    checks++;
    if (lat !== LAT || early || bdrop) begin
      errors++;
      $display("FAIL basic_timing: lat=%0d early=%0b busy_drop=%0b expected lat=%0d", lat, early, bdrop, LAT);
    end
    for (int j = 0; j < 10; j++) begin
      if (j == 4) begin
        start = 1'b1;
        count = 8'd3;
      end
      if (j >= 3 && j <= 6) begin
        in_valid = 1'b1;
        num = 32'(j + 9);
      end
      @(posedge clock); #1;
      start = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({sum, sum_valid, busy} !== {40'd36, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL done_hold[%0d]: sum=%0d sv=%0b busy=%0b expected 36/1/1", j, sum, sum_valid, busy);
      end
    end
    accept();
    checks++;
    if ({sum, sum_valid, busy} !== {40'd36, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_accept: sum=%0d sv=%0b busy=%0b expected 36/0/0", sum, sum_valid, busy);
    end
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      num = 32'd50;
      @(posedge clock); #1;
    end
    settle();
    checks++;
    if ({sum, sum_valid, busy} !== {40'd36, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_discard: sum=%0d sv=%0b busy=%0b expected 36/0/0", sum, sum_valid, busy);
    end
  endtask

  // count=0 goes straight to DONE with sum 0; sum_ready held high across
  // the DONE entry edge only takes effect one edge later.
  task automatic test_zero_count();
    start = 1'b1;
    count = 8'd0;
    sum_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if ({sum, sum_valid, busy} !== {40'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL zero_done: sum=%0d sv=%0b busy=%0b expected 0/1/1", sum, sum_valid, busy);
    end
    @(posedge clock); #1;
    sum_ready = 1'b0;
    checks++;
    if ({sum_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL zero_accept: sv=%0b busy=%0b expected 0/0", sum_valid, busy);
    end
    settle();
  endtask

  // Two terms separated by an idle gap; sum_ready held high during ACCUM
  // must be ignored.
  task automatic test_gap();
    logic [31:0] q[$];
    logic [39:0] s;
    int lat;
    bit early, bdrop;
    q = '{32'd5};
    start = 1'b1;
    count = 8'd2;
    sum_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    in_valid = 1'b1;
    num = 32'd5;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if ({sum, sum_valid, busy} !== {model_sum(q), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL gap_partial: sum=%0d sv=%0b busy=%0b expected %0d/0/1", sum, sum_valid, busy, model_sum(q));
    end
    q.push_back(32'd7);
    in_valid = 1'b1;
    num = 32'd7;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = -1;
    early = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clock); #1;
      if (sum_valid) begin
        lat = k;
        break;
      end
    end
    sum_ready = 1'b0;
    s = sum;
    checks++;
    if (s !== model_sum(q) || lat !== LAT) begin
      errors++;
      $display("FAIL gap_sum: got %0d lat=%0d expected %0d lat=%0d", s, lat, model_sum(q), LAT);
    end
    accept();
    settle();
  endtask

  // 255 terms of 0xFFFFFFFF, back to back.
  task automatic test_max();
    logic [31:0] q[$];
    logic [39:0] s;
    int lat;
    bit early, bdrop;
    for (int i = 0; i < 255; i++) q.push_back(32'hFFFF_FFFF);
    run_txn(255, q, 0, s, lat, early, bdrop);
    checks++;
    if (s !== 40'hFE_FFFF_FF01 || s !== model_sum(q)) begin
      errors++;
      $display("FAIL max_sum: got %0h expected %0h", s, 40'hFE_FFFF_FF01);
    end
    checks++;
    if (lat !== LAT || early || bdrop) begin
      errors++;
      $display("FAIL max_timing: lat=%0d early=%0b busy_drop=%0b expected lat=%0d", lat, early, bdrop, LAT);
    end
    accept();
    settle();
  endtask

  // Asynchronous reset mid-ACCUM, then a fresh single-term run.
  task automatic test_reset_abort();
    logic [31:0] q[$];
    logic [31:0] first2[$];
    logic [39:0] s;
    int lat;
    bit early, bdrop;
    q = '{32'd11, 32'd22, 32'd33, 32'd44};
    first2 = '{32'd11, 32'd22};
    start = 1'b1;
    count = 8'd4;
    @(posedge clock); #1;
    start = 1'b0;
    foreach (q[i]) begin
      in_valid = 1'b1;
      num = q[i];
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({sum, sum_valid, busy} !== {model_sum(first2), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_partial: sum=%0d sv=%0b busy=%0b expected %0d/0/1", sum, sum_valid, busy, model_sum(first2));
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({sum, sum_valid, busy} !== {40'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_async: sum=%0d sv=%0b busy=%0b expected 0/0/0", sum, sum_valid, busy);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    q = '{32'd2};
    run_txn(1, q, 0, s, lat, early, bdrop);
    checks++;
    if (s !== 40'd8 || lat !== LAT || early || bdrop) begin
      errors++;
      $display("FAIL abort_restart: sum=%0d lat=%0d early=%0b busy_drop=%0b expected 8 lat=%0d", s, lat, early, bdrop, LAT);
    end
    accept();
    settle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [39:0] s;
    int lat;
    bit early, bdrop;
    for (int i = 0; i < 16; i++) q.push_back($urandom);
    run_txn(16, q, 0, s, lat, early, bdrop);
    checks++;
    if (s !== model_sum(q) || lat !== LAT || early || bdrop) begin
      errors++;
      $display("FAIL b2b: got %0h lat=%0d early=%0b busy_drop=%0b expected %0h lat=%0d", s, lat, early, bdrop, model_sum(q), LAT);
    end
    accept();
    settle();
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [39:0] s;
    int lat, n, hold;
    bit early, bdrop;
    for (int t = 0; t < 8; t++) begin
      q.delete();
      n = int'($urandom_range(12, 1));
      for (int i = 0; i < n; i++) q.push_back($urandom);
      run_txn(n, q, 3, s, lat, early, bdrop);
      checks++;
      if (s !== model_sum(q) || lat !== LAT || early || bdrop) begin
        errors++;
        $display("FAIL rand[%0d]: got %0h lat=%0d early=%0b busy_drop=%0b expected %0h lat=%0d", t, s, lat, early, bdrop, model_sum(q), LAT);
      end
      hold = int'($urandom_range(3, 0));
      repeat (hold) @(posedge clock);
      #1;
      accept();
      checks++;
      if ({sum, sum_valid, busy} !== {model_sum(q), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rand_accept[%0d]: sum=%0h sv=%0b busy=%0b expected %0h/0/0", t, sum, sum_valid, busy, model_sum(q));
      end
      settle();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_gap();
    test_max();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
